moving_average_mc: RTL and testbench

Multi-channel, runtime-configurable moving-average filter, the parametrised successor of the single-channel 2^M-sample averager. Time-multiplexed samples from C independent channels arrive on one tagged input stream. Each channel keeps its own history buffer and running sum. The block emits a tagged, registered average per accepted sample once that channel's window has filled. It sits between sample producers and downstream consumers in the same filter datapath.

---
 rtl/moving_average_mc_if.sv | 36 +++
 rtl/moving_average_mc.sv | 114 +++++++++++
 tb/tb_moving_average_mc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/moving_average_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_mc_if
// Purpose  : Tagged sample-in / average-out bundle for moving_average_mc.
//            The master side produces samples and control. The slave side
//            (the filter) returns tagged averages.
// Revision : 1.0 - initial release
// ============================================================================
interface moving_average_mc_if #(
  parameter int M = 3,
  parameter int N = 8,
  parameter int C = 4
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = $clog2(M + 1);

  logic          clear;
  logic [KW-1:0] win_log2;
  logic [N-1:0]  sample;
  logic [CW-1:0] sample_ch;
  logic          sample_valid;
  logic [N-1:0]  average;
  logic [CW-1:0] average_ch;
  logic          average_valid;

  modport master (
    output clear, win_log2, sample, sample_ch, sample_valid,
    input  average, average_ch, average_valid
  );

  modport slave (
    input  clear, win_log2, sample, sample_ch, sample_valid,
    output average, average_ch, average_valid
  );
endinterface
`default_nettype wire

// File: rtl/moving_average_mc.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_mc
// Purpose  : Multi-channel moving-average filter. Each channel has its own
//            2^M-entry history, write pointer, fill counter and running sum.
//            The window 2^k is selected at runtime on clear. Output is
//            registered with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module moving_average_mc #(
  parameter int M = 3,
  parameter int N = 8,
  parameter int C = 4
) (
  input  logic               clk,
  input  logic               rst,
  moving_average_mc_if.slave bus
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = $clog2(M + 1);
  localparam int D  = 1 << M;

  // Per-channel storage and state
  logic [N-1:0]   buf_mem [C][D];
  logic [N+M-1:0] sum_q   [C];
  logic [M-1:0]   wp_q    [C];
  logic [M:0]     fc_q    [C];
  logic [KW-1:0]  k_q;

  // Datapath for the sample presented this cycle
  logic           in_range;
  logic           accept;
  logic [CW-1:0]  ch;
  logic [M:0]     win;
  logic           full;
  logic [M-1:0]   old_idx;
  logic [N-1:0]   old_val;
  logic [N+M-1:0] new_sum;
  logic [M+1:0]   fc_inc;
  logic           reach;
  logic [N-1:0]   avg_next;

  // Evaluate the window update for the incoming sample's channel
  always_comb begin
    in_range = (int'(bus.sample_ch) < C);
    accept   = bus.sample_valid && !bus.clear && in_range;
    // Redirect out-of-range tags to channel 0 so array reads stay in bounds.
    // accept is low for those tags, so nothing is updated.
    ch       = in_range ? bus.sample_ch : '0;
    win      = {{M{1'b0}}, 1'b1} << k_q;
    full     = (fc_q[ch] == win);
    // When the window is 2^M, the low M bits of win are zero. The sample that
    // leaves the window then sits at wp, and it is read before it is overwritten.
    old_idx  = wp_q[ch] - win[M-1:0];
    old_val  = full ? buf_mem[ch][old_idx] : '0;
    new_sum  = sum_q[ch] + {{M{1'b0}}, bus.sample} - {{M{1'b0}}, old_val};
    fc_inc   = {1'b0, fc_q[ch]} + 1'b1;
    reach    = (fc_inc >= {1'b0, win});
    avg_next = N'(new_sum >> k_q);
  end

  // Active window length, latched on clear and saturated to M
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= KW'(M);
    end else if (bus.clear) begin
      k_q <= (int'(bus.win_log2) > M) ? KW'(M) : bus.win_log2;
    end
  end

  // Per-channel sums, pointers and fill counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        sum_q[c] <= '0;
        wp_q[c]  <= '0;
        fc_q[c]  <= '0;
      end
    end else if (bus.clear) begin
      for (int c = 0; c < C; c++) begin
        sum_q[c] <= '0;
        wp_q[c]  <= '0;
        fc_q[c]  <= '0;
      end
    end else if (accept) begin
      sum_q[ch] <= new_sum;
      wp_q[ch]  <= wp_q[ch] + 1'b1;
      fc_q[ch]  <= reach ? win : fc_inc[M:0];
    end
  end

  // History buffer. Clear leaves it untouched because fc gating hides stale data.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[ch][wp_q[ch]] <= bus.sample;
    end
  end

  // Registered tagged result; average and tag hold when no result is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.average       <= '0;
      bus.average_ch    <= '0;
      bus.average_valid <= 1'b0;
    end else if (accept && reach) begin
      bus.average       <= avg_next;
      bus.average_ch    <= ch;
      bus.average_valid <= 1'b1;
    end else begin
      bus.average_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_moving_average_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_average_mc
// Purpose  : Scoreboard bench for moving_average_mc. The reference model keeps
//            the accepted samples of each channel and averages the most recent
//            2^k of them. A negedge monitor compares each output against the
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moving_average_mc;
  localparam int M  = 3;
  localparam int N  = 8;
  localparam int C  = 4;
  localparam int CW = 2;
  localparam int KW = 2;

  typedef struct packed {
    logic [N-1:0]  avg;
    logic [CW-1:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  moving_average_mc_if #(.M(M), .N(N), .C(C)) bus_a ();
  moving_average_mc_if #(.M(2), .N(8), .C(3)) bus_b ();

  moving_average_mc #(.M(M), .N(N), .C(C)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  moving_average_mc #(.M(2), .N(8), .C(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   hist [C][256];
  int   cnt  [C];
  int   k_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    k_m = M;
    for (int c = 0; c < C; c++) cnt[c] = 0;
  endfunction

  function automatic void model_clear(input int wl);
    k_m = (wl > M) ? M : wl;
    for (int c = 0; c < C; c++) cnt[c] = 0;
  endfunction

  // Record the sample. Return 1 with the expected result once the window is full.
  function automatic bit model_accept(input int ch, input int x, output exp_t e);
    int w;
    int s;
    e = '0;
    if (ch >= C) return 1'b0;
    hist[ch][cnt[ch] % 256] = x;
    cnt[ch]++;
    w = 1 << k_m;
    if (cnt[ch] < w) return 1'b0;
    s = 0;
    for (int i = 0; i < w; i++) s += hist[ch][(cnt[ch] - 1 - i) % 256];
    e.avg = N'(s >> k_m);
    e.ch  = CW'(ch);
    return 1'b1;
  endfunction

  task automatic send(input bit v, input int ch, input int x, input bit clr, input int wl);
    exp_t e;
    bit   has;
    has = 1'b0;
    e   = '0;
    bus_a.sample_valid = v;
    bus_a.sample_ch    = CW'(ch);
    bus_a.sample       = N'(x);
    bus_a.clear        = clr;
    bus_a.win_log2     = KW'(wl);
    if (clr) model_clear(wl);
    else if (v) has = model_accept(ch, x, e);
    @(posedge clk);
    if (has) exp_q.push_back(e);
    #1;
  endtask

  task automatic sendb(input bit v, input int ch, input int x, input bit clr, input int wl,
                       input bit ev, input int eavg, input int ech);
    bus_b.sample_valid = v;
    bus_b.sample_ch    = 2'(ch);
    bus_b.sample       = 8'(x);
    bus_b.clear        = clr;
    bus_b.win_log2     = 2'(wl);
    @(posedge clk);
    #1;
    check("b_valid", 64'(bus_b.average_valid), 64'(ev));
    if (ev) begin
      check("b_avg", 64'(bus_b.average), 64'(eavg));
      check("b_ch", 64'(bus_b.average_ch), 64'(ech));
    end
  endtask

  // Monitor: each cycle, a valid output must match the head of the scoreboard, and a
  // pending expectation must not go unanswered
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus_a.average_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("avg", 64'(bus_a.average), 64'(e.avg));
          check("avg_ch", 64'(bus_a.average_ch), 64'(e.ch));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_valid", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    model_reset();
    bus_a.clear = 0; bus_a.win_log2 = 0; bus_a.sample = 0; bus_a.sample_ch = 0; bus_a.sample_valid = 0;
    bus_b.clear = 0; bus_b.win_log2 = 0; bus_b.sample = 0; bus_b.sample_ch = 0; bus_b.sample_valid = 0;

    // Reset held while samples toggle: outputs stay at reset values
    for (int i = 0; i < 10; i++) begin
      bus_a.sample_valid = i[0];
      bus_a.sample       = N'(i * 10 + 1);
      @(posedge clk);
      #1;
      check("rst_avg", 64'(bus_a.average), 64'd0);
      check("rst_ch", 64'(bus_a.average_ch), 64'd0);
      check("rst_valid", 64'(bus_a.average_valid), 64'd0);
    end
    rst = 1'b0;

    // Default window of 8: valid only on the 8th sample
    for (int i = 0; i < 8; i++) begin
      send(1, 0, 10 + i, 0, 0);
      check("dflt_valid", 64'(bus_a.average_valid), (i == 7) ? 64'd1 : 64'd0);
    end

    // Window 4 on channel 0
    send(0, 0, 0, 1, 2);
    send(1, 0, 4, 0, 0);
    send(1, 0, 8, 0, 0);
    send(1, 0, 12, 0, 0);
    check("w4_novalid", 64'(bus_a.average_valid), 64'd0);
    send(1, 0, 16, 0, 0);
    check("w4_avg10", 64'(bus_a.average), 64'd10);
    send(1, 0, 20, 0, 0);
    check("w4_avg14", 64'(bus_a.average), 64'd14);

    // Interleave channels 1 and 2
    send(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 255, 0, 0);
      if (i == 3) check("il_ch1_avg", 64'(bus_a.average), 64'd255);
      send(1, 2, i + 1, 0, 0);
      if (i == 3) check("il_ch2_avg", 64'(bus_a.average), 64'd2);
    end

    // Truncation with window 2, then pass-through
    send(0, 0, 0, 1, 1);
    send(1, 3, 3, 0, 0);
    send(1, 3, 4, 0, 0);
    check("trunc_avg", 64'(bus_a.average), 64'd3);
    send(0, 0, 0, 1, 0);
    send(1, 3, 77, 0, 0);
    check("pass_valid", 64'(bus_a.average_valid), 64'd1);
    check("pass_avg", 64'(bus_a.average), 64'd77);

    // Clear colliding with a sample: the sample is dropped
    send(0, 0, 0, 1, 2);
    send(1, 0, 5, 0, 0);
    send(1, 0, 6, 0, 0);
    send(1, 0, 7, 0, 0);
    send(1, 0, 9, 1, 2);
    check("coll_novalid", 64'(bus_a.average_valid), 64'd0);
    for (int i = 0; i < 4; i++) send(1, 0, 1, 0, 0);
    check("coll_avg1", 64'(bus_a.average), 64'd1);
    send(0, 0, 0, 0, 0);

    // Saturating window request on the M=2, C=3 instance
    sendb(0, 0, 0, 1, 3, 0, 0, 0);
    sendb(1, 0, 8, 0, 0, 0, 0, 0);
    sendb(1, 0, 8, 0, 0, 0, 0, 0);
    sendb(1, 0, 8, 0, 0, 0, 0, 0);
    sendb(1, 0, 4, 0, 0, 1, 7, 0);
    sendb(1, 3, 200, 0, 0, 0, 0, 0);
    sendb(1, 0, 16, 0, 0, 1, 9, 0);
    sendb(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 60) == 0)
        send(bit'($urandom_range(0, 1)), 0, 5, 1, int'($urandom_range(0, 3)));
      else
        send($urandom_range(0, 3) != 0, int'($urandom_range(0, C - 1)),
             int'($urandom_range(0, 255)), 0, 0);
    end

    // Asynchronous reset in the middle of a cycle
    send(1, 1, 200, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_avg", 64'(bus_a.average), 64'd0);
    check("arst_ch", 64'(bus_a.average_ch), 64'd0);
    check("arst_valid", 64'(bus_a.average_valid), 64'd0);
    check("arst_b_avg", 64'(bus_b.average), 64'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // The window is back to 2^M after reset
    for (int i = 0; i < 8; i++) begin
      send(1, 1, 3 * i, 0, 0);
      check("post_rst_valid", 64'(bus_a.average_valid), (i == 7) ? 64'd1 : 64'd0);
    end

    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
